fb_scan_reader: RTL and testbench
=================================

# fb_scan_reader

Parametrised frame-buffer scan reader between the VGA timing counters and the grayscale image memory. It maps the live `H_Count_Value`/`V_Count_Value` position onto a memory address for a configurable image window (offset and integer upscale). It issues the memory reads and returns the pixel on `R`/`G`/`B` with fixed latency. It also supplies a border value outside the image and zero during blanking.

## Interface
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `IMG_W`, 320: stored image width in pixels.
- `IMG_H`, 240: stored image height in pixels.
- `X0`, 0: first display column of the image.
- `Y0`, 0: first display row of the image.
- `SCALE`, 2: pixel/line replication factor, 1 or 2. Constraints: `X0+IMG_W*SCALE <= H_ACTIVE` and `Y0+IMG_H*SCALE <= V_ACTIVE`.
- `PIX_W`, 8: pixel width.
- `ADDR_W`, 18: address width. Must satisfy `2^ADDR_W >= IMG_W*IMG_H`.
- `MEM_LAT`, 1: memory read latency in cycles, ≥1.
- `BORDER`, 8'h10: value shown outside the image inside the active area.

Ports:
- `clk`, in, 1: pixel clock. One counter step per cycle.
- `rst`, in, 1: synchronous, active-high reset.
- `Done`, in, 1: image ready. Sampled only at frame start.
- `H_Count_Value`, in, 10: current column.
- `V_Count_Value`, in, 10: current row.
- `mem_addr`, out, ADDR_W: registered read address.
- `mem_rd`, out, 1: read strobe, registered.
- `mem_data`, in, PIX_W: read data, valid `MEM_LAT` cycles after `mem_addr`/`mem_rd`.
- `R`, `G`, `B`, out, PIX_W each: grayscale pixel, all three equal.

## Operation
- Frame start means `H_Count_Value==0 && V_Count_Value==0`.
- In-image means `X0 <= H <= X1` and `Y0 <= V <= Y1`, where `X1 = X0+IMG_W*SCALE-1` and `Y1 = Y0+IMG_H*SCALE-1`.
- Active means `H < H_ACTIVE && V < V_ACTIVE`.
- State machine:
  - S_WAIT to S_SCAN at frame start when `Done`=1.
  - S_SCAN to S_WAIT at frame start when `Done`=0.
  - Otherwise the state holds, so image/border switching never tears mid-frame.
- Address generation uses registers `line_base` (ADDR_W), `col` (ADDR_W), `col_rep` and `row_rep` (1 bit each). There is no multiplier.
  - Frame start: `line_base`=0, `col`=0, `col_rep`=0, `row_rep`=0.
  - Each in-image cycle in S_SCAN: `mem_addr <= line_base+col`, `mem_rd <= 1`. Then `col_rep` advances; `col` increments when `col_rep==SCALE-1`.
  - At H==X1 on an in-image row: `col`=0 and `col_rep`=0. `row_rep` advances; when `row_rep==SCALE-1`, `row_rep`=0 and `line_base += IMG_W`.
  - Other cycles: `mem_rd <= 0`, `mem_addr` holds.
- A pixel class tag (IMAGE / BORDER / BLANK) is computed alongside the address and delayed to match memory latency.
- Output register: IMAGE takes `mem_data`, BORDER takes `BORDER`, BLANK takes 0.
- In S_WAIT, in-image pixels are tagged BORDER and no reads are issued.
- Address arithmetic is unsigned modulo 2^ADDR_W. Legal parameters never wrap.

## Timing
- Counters sampled at cycle t → `mem_addr`/`mem_rd` at t+1 → `mem_data` at t+1+MEM_LAT → `R`/`G`/`B` at t+2+MEM_LAT. Total latency is `MEM_LAT+2`, identical for all pixel classes.
- Reset values: `mem_addr`=0, `mem_rd`=0, `R`=`G`=`B`=0, all tags BLANK, state S_WAIT, all scan registers 0.
- Reset mid-frame: pipeline is flushed. Outputs are 0 until the first post-reset pixel emerges, `MEM_LAT+2` cycles after `rst` falls. Image reads resume only at the next frame start with `Done`=1.
- `Done` changing mid-frame has no effect until the next frame start.
- Frame start on an in-image pixel (X0=Y0=0): address reset and the first read happen in the same cycle, and `mem_addr` is 0.
- The bench checks X1 and Y1 at the final in-image column and row; there are no out-of-range reads.

## Test plan
Defaults unless stated. Memory model returns `addr[7:0]`.
- Reset with `Done`=0: `R`/`G`/`B`=0 while `rst`=1. After reset, the image area shows 8'h10, blanking (H=700) shows 0, and `mem_rd` stays 0.
- `Done`=1, first frame:
  - `mem_addr`=0 for H=0,1 and 1 for H=2,3; 319 at H=638,639.
  - `R` at H=3 (cycle t+3) is 0x00.
  - `R` for pixel H=2 is 0x01.
- Line repeat:
  - Rows V=0 and V=1 both start at addr 0.
  - V=2,H=0 gives addr 320, then output 0x40.
  - V=479,H=639 gives addr 76799, data 0xFF.
  - The next frame starts again at 0.
- Mid-frame drop: `Done`→0 at V=100 keeps the image until the frame ends. The next frame is all 8'h10 in the image area with `mem_rd`=0.
- Offset, X0=160, Y0=120, SCALE=1:
  - (159,120) gives BORDER.
  - (160,120) gives addr 0.
  - (479,359) gives addr 76799.
  - (480,120) gives BORDER.
  - (160,119) gives BORDER.
- Reset pulse at V=10,H=100: the next 3 outputs are 0. Only BORDER appears until the next frame start, then the image resumes at addr 0.

Source files
------------

// File: rtl/fb_scan_reader_if.sv
// Bus between the VGA timing counters, the image memory and the pixel output of fb_scan_reader.
interface fb_scan_reader_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 18
);
  logic              Done;
  logic [9:0]        H_Count_Value;
  logic [9:0]        V_Count_Value;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [PIX_W-1:0]  mem_data;
  logic [PIX_W-1:0]  R;
  logic [PIX_W-1:0]  G;
  logic [PIX_W-1:0]  B;

  // Scan reader side: consumes counters and read data, drives reads and pixels
  modport master (
    input  Done, H_Count_Value, V_Count_Value, mem_data,
    output mem_addr, mem_rd, R, G, B
  );

  // Environment side: timing generator, memory and display
  modport slave (
    output Done, H_Count_Value, V_Count_Value, mem_data,
    input  mem_addr, mem_rd, R, G, B
  );
endinterface

// File: rtl/fb_scan_reader.sv
// Frame-buffer scan reader: maps the live raster position onto image memory
// addresses (offset window, integer upscale) and returns the pixel with a fixed
// MEM_LAT+2 latency, a border value outside the image and zero in blanking.
module fb_scan_reader #(
  parameter int unsigned     H_ACTIVE = 640,
  parameter int unsigned     V_ACTIVE = 480,
  parameter int unsigned     IMG_W    = 320,
  parameter int unsigned     IMG_H    = 240,
  parameter int unsigned     X0       = 0,
  parameter int unsigned     Y0       = 0,
  parameter int unsigned     SCALE    = 2,
  parameter int unsigned     PIX_W    = 8,
  parameter int unsigned     ADDR_W   = 18,
  parameter int unsigned     MEM_LAT  = 1,
  parameter logic [PIX_W-1:0] BORDER  = PIX_W'(8'h10)
) (
  input  logic             clk,
  input  logic             rst,
  fb_scan_reader_if.master bus
);

  localparam int unsigned SPAN_X = IMG_W * SCALE;
  localparam int unsigned SPAN_Y = IMG_H * SCALE;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TAG_BLANK  = 2'd0,
    TAG_BORDER = 2'd1,
    TAG_IMAGE  = 2'd2
  } tag_e;

  state_e              r_state;
  state_e              w_state_nxt;

  logic [31:0]         w_h;
  logic [31:0]         w_v;
  logic [31:0]         w_dx;
  logic [31:0]         w_dy;
  logic                w_frame_start;
  logic                w_in_img;
  logic                w_active;
  logic                w_last_col;

  logic [ADDR_W-1:0]   r_line_base;
  logic [ADDR_W-1:0]   r_col;
  logic                r_col_rep;
  logic                r_row_rep;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rd;
  logic [MEM_LAT:0][1:0] r_tag;
  logic [PIX_W-1:0]    r_pix;

  logic [ADDR_W-1:0]   w_base_cur;
  logic [ADDR_W-1:0]   w_col_cur;
  logic                w_col_rep_cur;
  logic                w_row_rep_cur;
  logic                w_col_rep_last;
  logic                w_row_rep_last;

  logic [ADDR_W-1:0]   w_line_base_nxt;
  logic [ADDR_W-1:0]   w_col_nxt;
  logic                w_col_rep_nxt;
  logic                w_row_rep_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic                w_mem_rd_nxt;
  tag_e                w_tag_nxt;

  // Raster position decode; offsets wrap below the window so one compare covers both edges
  assign w_h           = 32'(bus.H_Count_Value);
  assign w_v           = 32'(bus.V_Count_Value);
  assign w_dx          = w_h - 32'(X0);
  assign w_dy          = w_v - 32'(Y0);
  assign w_frame_start = (bus.H_Count_Value == 10'd0) && (bus.V_Count_Value == 10'd0);
  assign w_in_img      = (w_dx < 32'(SPAN_X)) && (w_dy < 32'(SPAN_Y));
  assign w_last_col    = (w_dx == 32'(SPAN_X - 1));
  assign w_active      = (w_h < 32'(H_ACTIVE)) && (w_v < 32'(V_ACTIVE));

  // Scan registers as seen this cycle: frame start restarts the walk at address 0
  assign w_base_cur     = w_frame_start ? '0 : r_line_base;
  assign w_col_cur      = w_frame_start ? '0 : r_col;
  assign w_col_rep_cur  = w_frame_start ? 1'b0 : r_col_rep;
  assign w_row_rep_cur  = w_frame_start ? 1'b0 : r_row_rep;
  assign w_col_rep_last = (SCALE == 1) || w_col_rep_cur;
  assign w_row_rep_last = (SCALE == 1) || w_row_rep_cur;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_state_nxt;
  end

  // Image/border mode only changes at frame start so a frame never tears
  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_start) w_state_nxt = bus.Done ? S_SCAN : S_WAIT;
  end

  // Address walk and pixel class for the current raster position
  always_comb begin
    w_line_base_nxt = w_base_cur;
    w_col_nxt       = w_col_cur;
    w_col_rep_nxt   = w_col_rep_cur;
    w_row_rep_nxt   = w_row_rep_cur;
    w_mem_rd_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_tag_nxt       = TAG_BLANK;
    if (w_in_img && (w_state_nxt == S_SCAN)) begin
      w_tag_nxt      = TAG_IMAGE;
      w_mem_rd_nxt   = 1'b1;
      w_mem_addr_nxt = w_base_cur + w_col_cur;
      if (w_last_col) begin
        w_col_nxt     = '0;
        w_col_rep_nxt = 1'b0;
        if (w_row_rep_last) begin
          w_row_rep_nxt   = 1'b0;
          w_line_base_nxt = w_base_cur + ADDR_W'(IMG_W);
        end else begin
          w_row_rep_nxt = 1'b1;
        end
      end else if (w_col_rep_last) begin
        w_col_rep_nxt = 1'b0;
        w_col_nxt     = w_col_cur + ADDR_W'(1);
      end else begin
        w_col_rep_nxt = 1'b1;
      end
    end else if (w_active) begin
      w_tag_nxt = TAG_BORDER;
    end
  end

  // Scan registers, read request and class tag delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_base <= '0;
      r_col       <= '0;
      r_col_rep   <= 1'b0;
      r_row_rep   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_line_base <= w_line_base_nxt;
      r_col       <= w_col_nxt;
      r_col_rep   <= w_col_rep_nxt;
      r_row_rep   <= w_row_rep_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_tag       <= {r_tag[MEM_LAT-1:0], w_tag_nxt};
    end
  end

  // Output pixel selected by the tag that lines up with the returning read data
  always_ff @(posedge clk) begin
    if (rst)                                r_pix <= '0;
    else if (r_tag[MEM_LAT] == TAG_IMAGE)   r_pix <= bus.mem_data;
    else if (r_tag[MEM_LAT] == TAG_BORDER)  r_pix <= BORDER;
    else                                    r_pix <= '0;
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.R        = r_pix;
  assign bus.G        = r_pix;
  assign bus.B        = r_pix;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader: two instances (full-screen 2x and an
// offset 1x window) driven by the same raster, checked against a reference model.
`timescale 1ns/1ps
module tb_fb_scan_reader;

  localparam int unsigned MEM_LAT = 1;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int X0_A = 0;
  localparam int Y0_A = 0;
  localparam int SC_A = 2;
  localparam int X0_B = 160;
  localparam int Y0_B = 120;
  localparam int SC_B = 1;

  typedef struct {
    int due;
    int rd0;
    int addr0;
    int rd1;
    int addr1;
  } mexp_t;

  typedef struct {
    int due;
    int pix0;
    int pix1;
  } pexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mexp_t q_mem[$];
  pexp_t q_pix[$];

  bit m_scan [2];
  int m_k    [2];
  int m_last [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_scan_reader_if #(.PIX_W(8), .ADDR_W(18)) bus_a ();
  fb_scan_reader_if #(.PIX_W(8), .ADDR_W(18)) bus_b ();

  fb_scan_reader #(.X0(X0_A), .Y0(Y0_A), .SCALE(SC_A), .MEM_LAT(MEM_LAT))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  fb_scan_reader #(.X0(X0_B), .Y0(Y0_B), .SCALE(SC_B), .MEM_LAT(MEM_LAT))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Memory returns the low address byte one cycle after the request
  always @(posedge clk) begin
    bus_a.mem_data <= bus_a.mem_addr[7:0];
    bus_b.mem_data <= bus_b.mem_addr[7:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: image row from V, stored column = visited in-image pixels in the row / SCALE
  task automatic model(input int d, input int h, input int v, input bit dn, input bit rs,
                       output int rd, output int addr, output int pix);
    int  x0, y0, sc;
    bit  in_img;
    x0 = (d == 0) ? X0_A : X0_B;
    y0 = (d == 0) ? Y0_A : Y0_B;
    sc = (d == 0) ? SC_A : SC_B;
    in_img = (h >= x0) && (h < x0 + IMG_W * sc) && (v >= y0) && (v < y0 + IMG_H * sc);
    rd  = 0;
    pix = (h < 640 && v < 480) ? 32'h10 : 0;
    if (rs) begin
      m_scan[d] = 1'b0;
      m_last[d] = 0;
      pix = 0;
    end else begin
      if (h == 0 && v == 0) begin
        m_scan[d] = dn;
        m_k[d]    = 0;
      end
      if (in_img && m_scan[d]) begin
        rd        = 1;
        m_last[d] = ((v - y0) / sc) * IMG_W + m_k[d] / sc;
        pix       = m_last[d] % 256;
        m_k[d]    = (h == x0 + IMG_W * sc - 1) ? 0 : m_k[d] + 1;
      end
    end
    addr = m_last[d];
  endtask

  task automatic step(input int h, input int v, input bit dn, input bit rs);
    mexp_t me;
    pexp_t pe;
    int rd, a, p;
    @(posedge clk);
    #1;
    rst = rs;
    bus_a.H_Count_Value = 10'(h);
    bus_a.V_Count_Value = 10'(v);
    bus_a.Done          = dn;
    bus_b.H_Count_Value = 10'(h);
    bus_b.V_Count_Value = 10'(v);
    bus_b.Done          = dn;
    if (rs) begin
      foreach (q_pix[i]) begin
        if (q_pix[i].due > cyc) begin
          q_pix[i].pix0 = 0;
          q_pix[i].pix1 = 0;
        end
      end
    end
    model(0, h, v, dn, rs, rd, a, p);
    me.rd0 = rd; me.addr0 = a; pe.pix0 = p;
    model(1, h, v, dn, rs, rd, a, p);
    me.rd1 = rd; me.addr1 = a; pe.pix1 = p;
    me.due = cyc + 1;
    pe.due = cyc + 2 + int'(MEM_LAT);
    q_mem.push_back(me);
    q_pix.push_back(pe);
  endtask

  // One frame: full rows at the interesting lines, sparse rows elsewhere (always hitting both X1s)
  task automatic run_frame(input bit done_start, input int drop_v, input int rst_v, input int rst_h);
    int hs[$];
    int ra;
    ra = $urandom_range(4, 478);
    for (int v = 0; v < 482; v++) begin
      hs.delete();
      if (v >= 480) begin
        hs.push_back(0); hs.push_back(320); hs.push_back(700);
      end else if ((v inside {0, 1, 2, 10, 119, 120, 359, 479}) || v == ra) begin
        for (int h = 0; h < 640; h++) hs.push_back(h);
        hs.push_back(640); hs.push_back(700); hs.push_back(799);
      end else begin
        if ($urandom_range(0, 1) == 1) hs.push_back($urandom_range(0, 239));
        if ($urandom_range(0, 1) == 1) hs.push_back($urandom_range(240, 478));
        hs.push_back(479);
        if ($urandom_range(0, 1) == 1) hs.push_back($urandom_range(480, 638));
        hs.push_back(639);
        hs.push_back(700);
      end
      foreach (hs[i]) begin
        bit dn;
        bit rs;
        if (v == 0 && hs[i] == 0) dn = done_start;
        else if (drop_v >= 0)     dn = (v < drop_v);
        else                      dn = 1'($urandom_range(0, 1));
        rs = (v == rst_v) && (hs[i] == rst_h);
        step(hs[i], v, dn, rs);
      end
    end
  endtask

  // Monitor: compares every presented output against the expectation due this cycle
  initial begin
    mexp_t me;
    pexp_t pe;
    forever begin
      @(negedge clk);
      if (q_mem.size() > 0 && q_mem[0].due <= cyc) begin
        me = q_mem.pop_front();
        chk("a_mem_rd",   32'(bus_a.mem_rd),   32'(me.rd0));
        chk("a_mem_addr", 32'(bus_a.mem_addr), 32'(me.addr0));
        chk("b_mem_rd",   32'(bus_b.mem_rd),   32'(me.rd1));
        chk("b_mem_addr", 32'(bus_b.mem_addr), 32'(me.addr1));
      end
      if (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
        pe = q_pix.pop_front();
        chk("a_R", 32'(bus_a.R), 32'(pe.pix0));
        chk("a_G", 32'(bus_a.G), 32'(pe.pix0));
        chk("a_B", 32'(bus_a.B), 32'(pe.pix0));
        chk("b_R", 32'(bus_b.R), 32'(pe.pix1));
        chk("b_G", 32'(bus_b.G), 32'(pe.pix1));
        chk("b_B", 32'(bus_b.B), 32'(pe.pix1));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) step(700, 500, 1'b0, 1'b1);
    run_frame(1'b0, -1, -1, -1);
    run_frame(1'b1, -1, -1, -1);
    run_frame(1'b1, -1, -1, -1);
    run_frame(1'b1, 100, -1, -1);
    run_frame(1'b0, -1, -1, -1);
    run_frame(1'b1, -1, 10, 100);
    run_frame(1'b1, -1, -1, -1);
    for (int i = 0; i < 4; i++) step(700, 500, 1'b0, 1'b0);
    for (int i = 0; i < 10 && (q_mem.size() > 0 || q_pix.size() > 0); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_mem", 32'(q_mem.size()), 32'd0);
    chk("drain_pix", 32'(q_pix.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
